// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared types and constants for the byte-serial adder controller.
package byte_serial_add_ctrl_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_serial_add_ctrl_if.sv
// Request/result bundle for byte_serial_add_ctrl.
// Optional BYTE_SERIAL_SUB_EN adds the sub_op request bit.
interface byte_serial_add_ctrl_if
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
);

  logic                       start;
  logic [BYTE_W*NBYTES-1:0]   a_in;
  logic [BYTE_W*NBYTES-1:0]   b_in;
  logic                       cin;
`ifdef BYTE_SERIAL_SUB_EN
  logic                       sub_op;
`endif
  logic                       busy;
  logic                       done;
  logic [BYTE_W*NBYTES-1:0]   sum_out;
  logic                       cout_out;

  // Requester side
  modport master (
    output start, a_in, b_in, cin,
`ifdef BYTE_SERIAL_SUB_EN
    output sub_op,
`endif
    input  busy, done, sum_out, cout_out
  );

  // Controller side
  modport slave (
    input  start, a_in, b_in, cin,
`ifdef BYTE_SERIAL_SUB_EN
    input  sub_op,
`endif
    output busy, done, sum_out, cout_out
  );

endinterface

// File: rtl/byte_serial_add_ctrl_carrySellect8.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is computed
// for both carry-in values and the low-nibble carry picks one.
module carrySellect8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_lo;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;

  assign w_lo  = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_cin};
  assign w_hi0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
  assign w_hi1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;

  assign o_sum  = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
  assign o_cout = w_lo[4] ? w_hi1[4] : w_hi0[4];

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial wide adder: one shared 8-bit adder, one limb per cycle, LSB first.
// Optional BYTE_SERIAL_SUB_EN: sub_op=1 computes A-B (cout_out=1 means no borrow).
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one limb added per cycle, index 0..NBYTES-1
// DONE  | result/carry copied to outputs, done flagged
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  byte_serial_add_ctrl_if.slave bus
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_res;
  logic             r_carry;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [BYTE_W-1:0] w_a_limb;
  logic [BYTE_W-1:0] w_b_limb;
  logic [BYTE_W-1:0] w_sum;
  logic              w_cout;

  // Current limb of each captured operand feeds the shared adder.
  assign w_a_limb = r_a[BYTE_W*r_idx +: BYTE_W];
  assign w_b_limb = r_b[BYTE_W*r_idx +: BYTE_W];

  carrySellect8 u_add (
    .i_a    (w_a_limb),
    .i_b    (w_b_limb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Sequencer FSM with registered outputs. done rises together with the
  // sum_out/cout_out load that happens while in DONE, so the pulse always
  // flags freshly valid data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a <= bus.a_in;
`ifdef BYTE_SERIAL_SUB_EN
            // Subtraction: A + ~B + 1; inverting at capture keeps the adder path plain.
            r_b     <= bus.sub_op ? ~bus.b_in : bus.b_in;
            r_carry <= bus.sub_op ? 1'b1 : bus.cin;
`else
            r_b     <= bus.b_in;
            r_carry <= bus.cin;
`endif
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res[BYTE_W*r_idx +: BYTE_W] <= w_sum;
          r_carry <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_sum   <= r_res;
          r_cout  <= r_carry;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum_out  = r_sum;
  assign bus.cout_out = r_cout;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Scoreboard bench for byte_serial_add_ctrl (NBYTES=4).
module tb_byte_serial_add_ctrl;
  import byte_serial_add_ctrl_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  byte_serial_add_ctrl_if #(.NBYTES(NB)) bus ();

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   n_done    = 0;
  int   cyc       = 0;
  int   start_cyc = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    logic [W:0] t;
    if (sub) t = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum  = t[W-1:0];
    e.cout = t[W];
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      exp_t e;
      n_done++;
      check("done_has_pending_op", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sum_out", 64'(bus.sum_out), 64'(e.sum));
        check("cout_out", 64'(bus.cout_out), 64'(e.cout));
      end
    end
  end

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic sub);
    @(negedge clk);
    bus.a_in  = a;
    bus.b_in  = b;
    bus.cin   = cin;
`ifdef BYTE_SERIAL_SUB_EN
    bus.sub_op = sub;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    start_cyc = cyc;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) break;
      @(negedge clk);
    end
    check("done_seen", 64'(bus.done), 64'd1);
    check("latency", 64'(cyc - start_cyc), 64'(NB + 1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
    q.push_back(model(a, b, cin, sub));
    drive_start(a, b, cin, sub);
    wait_done();
  endtask

  initial begin
    int n0;
    exp_t last;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    bus.cin   = 1'b0;
`ifdef BYTE_SERIAL_SUB_EN
    bus.sub_op = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_sum", 64'(bus.sum_out), 64'd0);
    check("rst_cout", 64'(bus.cout_out), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    run_op(32'h000000C7, 32'h00000037, 1'b0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);

    // Outputs hold after the done pulse.
    repeat (4) @(negedge clk);
    check("hold_sum", 64'(bus.sum_out), 64'h00000000ACF13569);
    check("hold_done_low", 64'(bus.done), 64'd0);

    // Start pulsed during RUN is ignored.
    n0 = n_done;
    q.push_back(model(32'h11111111, 32'h22222222, 1'b0, 1'b0));
    drive_start(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    @(negedge clk);
    bus.a_in  = 32'hFFFFFFFF;
    bus.b_in  = 32'hFFFFFFFF;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done === 1'b1) break;
      @(negedge clk);
    end
    check("busy_test_done_seen", 64'(bus.done), 64'd1);
    repeat (10) @(negedge clk);
    check("busy_test_done_count", 64'(n_done - n0), 64'd1);

    // Reset while RUN is on limb index 2: no done, outputs cleared.
    n0 = n_done;
    drive_start(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(bus.sum_out), 64'd0);
    check("abort_cout", 64'(bus.cout_out), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_done", 64'(n_done - n0), 64'd0);
    run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0);

    // Random operands.
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef BYTE_SERIAL_SUB_EN
    run_op(32'h00000005, 32'h00000059, 1'b0, 1'b1);
    run_op(32'h00001000, 32'h00000001, 1'b0, 1'b1);
    run_op(32'h80000000, 32'h00000001, 1'b1, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
